prim_unpacker: RTL
==================

// Module: prim_unpacker
// PURPOSE
//  Wide-to-narrow gearbox placed directly downstream of prim_packer.
//  Accepts full InW-bit data/mask words, holds one word, and emits it as InW/OutW narrow beats.
//  Beats whose mask slice is all-zero are skipped. The final emitted beat of each word is tagged last_o.
//  Flush handshake mirrors the packer: drain the held word, then pulse done.
// PARAMETERS
//  InW   32  input word width; must be an integer multiple of OutW (elaboration error otherwise)
//  OutW   8  output beat width; Beats = InW/OutW, beat index width IdxW = max(1,$clog2(Beats))
// PORTS
//  clk_i         in   1     clock; all state updates on posedge
//  rst_ni        in   1     reset, synchronous, active-low
//  valid_i       in   1     input word valid
//  data_i        in   InW   input word data
//  mask_i        in   InW   input word bit mask
//  ready_o       out  1     word accepted when valid_i & ready_o
//  valid_o       out  1     output beat valid
//  data_o        out  OutW  beat data = held data slice & held mask slice
//  mask_o        out  OutW  beat mask slice
//  last_o        out  1     beat is the highest nonzero-mask slice of the held word
//  ready_i       in   1     beat accepted when valid_o & ready_i
//  flush_i       in   1     request: drain held word, then signal done
//  flush_done_o  out  1     one-cycle pulse when flush completes
// BEHAVIOUR
//  Reset (rst_ni=0 at posedge): FSM=Idle; held data/mask=0; idx=0.
//   Outputs then: valid_o=0, data_o=0, mask_o=0, last_o=0, ready_o=1, flush_done_o=0.
//   Reset mid-word discards the held word; no beat is emitted for it.
//  Handshake:
//   ack_in=valid_i&ready_o; ack_out=valid_o&ready_i.
//   valid_o/data_o/mask_o/last_o stay stable while valid_o&!ready_i.
//  Beat selection (nz[k] = |held_mask[k*OutW+:OutW]):
//   idx on capture = lowest k with nz[k]; after each ack_out, idx = next k>idx with nz[k].
//   last_o = (no k>idx with nz[k]).
//  FSM:
//   Idle:
//    valid_o=0, ready_o=!flush_i.
//    ack_in with mask_i!=0 -> capture word, -> Busy.
//    ack_in with mask_i==0 -> word dropped, stay Idle, no beat.
//    flush_i -> flush_done_o=1 this same cycle (combinational), stay Idle.
//   Busy:
//    valid_o=1.
//    ready_o=ack_out&last_o (back-to-back; ready_i->ready_o comb path is intentional).
//    ack_out&!last_o -> advance idx.
//    ack_out&last_o&ack_in&mask_i!=0 -> capture new word, stay Busy (no bubble).
//    ack_out&last_o otherwise -> Idle; if flush pending, -> FlushDone instead.
//    flush_i in Busy latches flush pending, and ready_o is forced 0 until flush done.
//   FlushDone:
//    flush_done_o=1 for exactly one cycle, valid_o=0, ready_o=0 -> Idle.
//  Latency: word accepted at posedge t -> first beat valid_o=1 in cycle t+1.
//   Throughput: one beat per cycle; Beats beats/word max.
//  Simultaneous events:
//   flush_i&valid_i both high -> flush wins; ready_o=0 and the word is not accepted.
//   flush_i while already pending or in FlushDone -> ignored (no second pulse).
// TESTING
//  InW=32,OutW=8; word data=0xDDCCBBAA, mask=0xFFFFFFFF, ready_i=1
//   -> beats AA,BB,CC,DD on cycles t+1..t+4; last_o only on DD; ready_o=1 in t+4.
//  mask=0xFF00FF00, data=0x44332211
//   -> exactly 2 beats: 0x22 (mask FF), then 0x44 (mask FF, last_o=1).
//  mask=0
//   -> accepted, no valid_o; ready_o stays 1.
//  Back-to-back two full words with ready_i=1
//   -> 8 consecutive beats, no gap between DD and next AA.
//  ready_i held 0 for 5 cycles mid-word
//   -> valid_o=1 and data_o/mask_o/last_o unchanged throughout.
//  flush_i during beat 2 of full word
//   -> beats 3,4 emitted, next cycle flush_done_o=1 for one cycle.
//   Flush in Idle -> same-cycle flush_done_o=1.
//   rst_ni=0 mid-word -> next cycle valid_o=0, ready_o=1.

Source files
------------

// File: rtl/prim_unpacker.sv
// Wide-to-narrow gearbox: holds one InW-bit data/mask word and emits it as OutW-bit beats,
// skipping all-zero mask slices; first beat one cycle after capture, ready_o is backpressured by beat acceptance.
module prim_unpacker #(
  parameter int InW  = 32,
  parameter int OutW = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,

  input  logic            valid_i,
  input  logic [InW-1:0]  data_i,
  input  logic [InW-1:0]  mask_i,
  output logic            ready_o,

  output logic            valid_o,
  output logic [OutW-1:0] data_o,
  output logic [OutW-1:0] mask_o,
  output logic            last_o,
  input  logic            ready_i,

  input  logic            flush_i,
  output logic            flush_done_o
);

  localparam int Beats = InW / OutW;
  localparam int IdxW  = (Beats > 1) ? $clog2(Beats) : 1;

  if ((InW % OutW) != 0) begin : g_bad_width
    $error("prim_unpacker: InW must be an integer multiple of OutW");
  end

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StBusy      = 2'd1,
    StFlushDone = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [InW-1:0]    held_data_q;
  logic [InW-1:0]    held_mask_q;
  logic [IdxW-1:0]   idx_q;
  logic              flush_pend_q, flush_pend_d;

  logic [Beats-1:0]  nz_held;
  logic [Beats-1:0]  nz_in;
  logic              in_any;
  logic [IdxW-1:0]   first_idx;
  logic [IdxW-1:0]   next_idx;
  logic              has_next;
  logic [OutW-1:0]   beat_data;
  logic [OutW-1:0]   beat_mask;
  logic              capture;
  logic              advance;

  always_comb begin
    nz_held = '0;
    nz_in   = '0;
    for (int k = 0; k < Beats; k++) begin
      nz_held[k] = |held_mask_q[k*OutW +: OutW];
      nz_in[k]   = |mask_i[k*OutW +: OutW];
    end
  end

  assign in_any = |nz_in;

  // Descending scans so the last hit is the lowest qualifying index.
  always_comb begin
    first_idx = '0;
    next_idx  = idx_q;
    has_next  = 1'b0;
    for (int k = Beats - 1; k >= 0; k--) begin
      if (nz_in[k]) begin
        first_idx = IdxW'(k);
      end
      if (nz_held[k] && (k > int'(idx_q))) begin
        next_idx = IdxW'(k);
        has_next = 1'b1;
      end
    end
  end

  always_comb begin
    beat_data = '0;
    beat_mask = '0;
    for (int k = 0; k < Beats; k++) begin
      if (int'(idx_q) == k) begin
        beat_data = held_data_q[k*OutW +: OutW];
        beat_mask = held_mask_q[k*OutW +: OutW];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    valid_o      = 1'b0;
    ready_o      = 1'b0;
    flush_done_o = 1'b0;
    capture      = 1'b0;
    advance      = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready_o      = !flush_i;
        flush_done_o = flush_i;
        if (valid_i && !flush_i && in_any) begin
          capture = 1'b1;
          state_d = StBusy;
        end
      end
      StBusy: begin
        valid_o = 1'b1;
        if (flush_i) begin
          flush_pend_d = 1'b1;
        end
        // Refill on the final beat so back-to-back words stream without a bubble.
        ready_o = ready_i && !has_next && !flush_pend_q && !flush_i;
        if (ready_i) begin
          if (has_next) begin
            advance = 1'b1;
          end else if (valid_i && ready_o && in_any) begin
            capture = 1'b1;
          end else begin
            state_d = flush_pend_d ? StFlushDone : StIdle;
          end
        end
      end
      StFlushDone: begin
        flush_done_o = 1'b1;
        flush_pend_d = 1'b0;
        state_d      = StIdle;
      end
      default: begin
        state_d      = StIdle;
        flush_pend_d = 1'b0;
      end
    endcase
  end

  assign data_o = valid_o ? (beat_data & beat_mask) : '0;
  assign mask_o = valid_o ? beat_mask : '0;
  assign last_o = valid_o && !has_next;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      flush_pend_q <= 1'b0;
      held_data_q  <= '0;
      held_mask_q  <= '0;
      idx_q        <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      if (capture) begin
        held_data_q <= data_i;
        held_mask_q <= mask_i;
        idx_q       <= first_idx;
      end else if (advance) begin
        idx_q <= next_idx;
      end
    end
  end

endmodule
